onehot_decoder_seq: RTL and testbench

Registered, parametrised N-to-2^N decoder. Generalises the 3-to-8 combinational decoder to any input width. Adds a valid/ready input handshake, a thermometer mode and an auto-scan mode that walks the active output with a programmable dwell time. Used as the select/strobe generator for multi-channel datapaths, e.g. LED/segment scanning and mux select lines.

---
 rtl/onehot_decoder_seq.sv | 101 ++++++++++
 tb/tb_onehot_decoder_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/onehot_decoder_seq.sv
// rtl/onehot_decoder_seq.sv - registered N-to-2^N decoder with one-hot, thermometer and auto-scan modes
module onehot_decoder_seq #(
  parameter int IN_W    = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**IN_W)-1:0]  out,
  output logic                  out_valid,
  output logic                  busy
);
  localparam int OUT_W = 2**IN_W;

  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

  state_t               state;
  logic [IN_W-1:0]      pos;
  logic [IN_W-1:0]      pos_nx;
  logic [DWELL_W-1:0]   cnt;
  logic [DWELL_W-1:0]   dwell_q;

  function automatic logic [OUT_W-1:0] onehot(input logic [IN_W-1:0] c);
    return OUT_W'(1) << c;
  endfunction

  function automatic logic [OUT_W-1:0] therm(input logic [IN_W-1:0] c);
    logic [OUT_W-1:0] t;
    for (int i = 0; i < OUT_W; i++) t[i] = (i <= int'(c));
    return t;
  endfunction

  assign in_ready = en && !rst;
  // Natural IN_W-bit wrap gives OUT_W-1 -> 0 for free.
  assign pos_nx   = pos + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      pos       <= '0;
      cnt       <= '0;
      dwell_q   <= '0;
    end else if (!en) begin
      state     <= IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      pos       <= '0;
      cnt       <= '0;
      dwell_q   <= '0;
    end else if (in_valid) begin
      // An accept always wins over a pending scan advance.
      out_valid <= 1'b1;
      pos       <= in;
      case (mode)
        2'b10: begin
          state   <= SCAN;
          out     <= onehot(in);
          busy    <= 1'b1;
          cnt     <= dwell;
          dwell_q <= dwell;
        end
        2'b01: begin
          state   <= HOLD;
          out     <= therm(in);
          busy    <= 1'b0;
          cnt     <= '0;
          dwell_q <= '0;
        end
        default: begin
          state   <= HOLD;
          out     <= onehot(in);
          busy    <= 1'b0;
          cnt     <= '0;
          dwell_q <= '0;
        end
      endcase
    end else begin
      case (state)
        SCAN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            pos <= pos_nx;
            out <= onehot(pos_nx);
            cnt <= dwell_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_onehot_decoder_seq.sv
// tb/tb_onehot_decoder_seq.sv - randomized and directed bench for onehot_decoder_seq
module tb_onehot_decoder_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_code;
  logic [7:0]  dwell;
  logic [7:0]  out;
  logic        out_valid;
  logic        busy;

  logic        en4;
  logic [1:0]  mode4;
  logic        in_valid4;
  logic        in_ready4;
  logic [3:0]  in4;
  logic [7:0]  dwell4;
  logic [15:0] out4;
  logic        out_valid4;
  logic        busy4;

  int errors = 0;
  int checks = 0;

  // Reference: what is held, or where a scan started and how long ago.
  int m_kind = 0;
  int m_val, m_start, m_dwell, m_age;

  always #5 clk = ~clk;

  onehot_decoder_seq #(.IN_W(3), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .in(in_code), .dwell(dwell), .out(out),
    .out_valid(out_valid), .busy(busy)
  );

  onehot_decoder_seq #(.IN_W(4), .DWELL_W(8)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .mode(mode4), .in_valid(in_valid4),
    .in_ready(in_ready4), .in(in4), .dwell(dwell4), .out(out4),
    .out_valid(out_valid4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_out();
    if (m_kind == 1) return m_val;
    if (m_kind == 2) return 1 << ((m_start + m_age / (m_dwell + 1)) % 8);
    return 0;
  endfunction

  task automatic model_edge();
    if (!en) m_kind = 0;
    else if (in_valid) begin
      if (mode == 2'b10) begin
        m_kind = 2; m_start = int'(in_code); m_dwell = int'(dwell); m_age = 0;
      end else if (mode == 2'b01) begin
        m_kind = 1; m_val = (1 << (int'(in_code) + 1)) - 1;
      end else begin
        m_kind = 1; m_val = 1 << int'(in_code);
      end
    end else if (m_kind == 2) m_age++;
  endtask

  task automatic check_all();
    check("out", 32'(out), 32'(exp_out()));
    check("out_valid", 32'(out_valid), 32'(m_kind != 0));
    check("busy", 32'(busy), 32'(m_kind == 2));
    check("in_ready", 32'(in_ready), 32'(en && !rst));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic accept(input logic [1:0] md, input logic [2:0] code, input logic [7:0] dw);
    in_valid = 1'b1; mode = md; in_code = code; dwell = dw;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'b00; in_valid = 1'b0; in_code = '0; dwell = '0;
    en4 = 1'b0; mode4 = 2'b00; in_valid4 = 1'b0; in4 = '0; dwell4 = '0;
    repeat (2) @(negedge clk);
    check("rst_out", 32'(out), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;
    #1 check("ready_after_rst", 32'(in_ready), 32'h1);

    for (int i = 0; i < 8; i++) begin
      accept(2'b00, 3'(i), 8'd0);
      check("onehot_sweep", 32'(out), 32'(1 << i));
    end
    repeat (2) step();
    check("onehot_hold", 32'(out), 32'h80);

    accept(2'b01, 3'd3, 8'd0); check("therm3", 32'(out), 32'h0F);
    accept(2'b01, 3'd7, 8'd0); check("therm7", 32'(out), 32'hFF);
    accept(2'b01, 3'd0, 8'd0); check("therm0", 32'(out), 32'h01);
    accept(2'b11, 3'd2, 8'd0); check("mode11", 32'(out), 32'h04);

    accept(2'b10, 3'd6, 8'd2); check("scan_start", 32'(out), 32'h40);
    repeat (2) step();         check("scan_dwell", 32'(out), 32'h40);
    step();                    check("scan_adv", 32'(out), 32'h80);
    repeat (3) step();         check("scan_wrap", 32'(out), 32'h01);
    check("scan_busy", 32'(busy), 32'h1);
    accept(2'b10, 3'd5, 8'd0);
    repeat (5) step();

    // Override lands on a cycle where dwell=0 would advance.
    accept(2'b00, 3'd1, 8'd0);
    check("override_out", 32'(out), 32'h02);
    check("override_busy", 32'(busy), 32'h0);
    en = 1'b0; step(); check("en_low_out", 32'(out), 32'h00);
    en = 1'b1; step(); check("en_back_out", 32'(out), 32'h00);

    accept(2'b10, 3'd2, 8'd1);
    repeat (2) step();
    rst = 1'b1;
    #1;
    check("async_rst_out", 32'(out), 32'h0);
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    m_kind = 0;
    rst = 1'b0;
    accept(2'b00, 3'd5, 8'd0);
    check("after_rst_accept", 32'(out), 32'h20);

    for (int n = 0; n < 400; n++) begin
      en       = ($urandom_range(0, 15) != 0);
      in_valid = ($urandom_range(0, 3) == 0);
      mode     = 2'($urandom_range(0, 3));
      in_code  = 3'($urandom_range(0, 7));
      dwell    = 8'($urandom_range(0, 3));
      step();
    end
    en = 1'b1; in_valid = 1'b0;

    en4 = 1'b1; in_valid4 = 1'b1; mode4 = 2'b00; in4 = 4'd15;
    step(); check("w4_onehot15", 32'(out4), 32'h8000);
    mode4 = 2'b10; dwell4 = 8'd0;
    step(); check("w4_scan15", 32'(out4), 32'h8000);
    check("w4_busy", 32'(busy4), 32'h1);
    in_valid4 = 1'b0;
    step(); check("w4_wrap", 32'(out4), 32'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
